// File: rtl/buart_fifo_pkg.sv
// Shared types and helpers for the UART buffering stage.
// Pointer width helper and the TX handoff state encoding.
package buart_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tx_state_t;

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/buart_fifo_byte_fifo.sv
// Byte-wide FIFO with first-word-fall-through head and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo
  import buart_fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          drop,
  output logic [AW:0]   count
);

  localparam int PW = ptr_w(AW);

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/buart_fifo.sv
// CPU-side buffering between the IO port and the byte UART.
// RX FIFO drains the UART; TX FIFO feeds it via a two-state handoff.
module buart_fifo
  import buart_fifo_pkg::*;
#(
  parameter int RX_AW = 4,
  parameter int TX_AW = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_wr,
  input  logic [7:0]       io_wdata,
  input  logic             io_rd,
  output logic [7:0]       io_rdata,
  output logic             rx_avail,
  output logic             tx_full,
  output logic [RX_AW:0]   rx_count,
  output logic [TX_AW:0]   tx_count,
  output logic             rx_overflow,
  output logic             tx_drop,
  input  logic             clr_err,
  output logic             uart_wr,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_busy,
  output logic             uart_rd,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_valid
);

  logic [7:0] rx_head;
  logic       rx_empty;
  logic       rx_drop;
  logic [7:0] tx_head;
  logic       tx_empty;
  logic       tx_drop_now;
  logic       tx_pop;
  tx_state_t  state;
  tx_state_t  state_nxt;

  byte_fifo #(.AW(RX_AW)) u_rx (
    .clk   (clk),
    .rst_n (resetq),
    .push  (uart_valid),
    .pop   (io_rd),
    .wdata (uart_rx_data),
    .rdata (rx_head),
    .empty (rx_empty),
    .drop  (rx_drop),
    .count (rx_count)
  );

  byte_fifo #(.AW(TX_AW)) u_tx (
    .clk   (clk),
    .rst_n (resetq),
    .push  (io_wr),
    .pop   (tx_pop),
    .wdata (io_wdata),
    .rdata (tx_head),
    .empty (tx_empty),
    .drop  (tx_drop_now),
    .count (tx_count)
  );

  // Storage is not reset, so the head is masked while in reset.
  assign io_rdata = resetq ? rx_head : 8'h00;
  assign uart_rd  = uart_valid & resetq;
  assign rx_avail = ~rx_empty;
  assign tx_full  = tx_count[TX_AW];

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_empty && !uart_busy) begin
          tx_pop    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state        <= IDLE;
      uart_wr      <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      state   <= state_nxt;
      uart_wr <= tx_pop;
      if (tx_pop) uart_tx_data <= tx_head;
    end
  end

  // A fresh error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_overflow <= 1'b0;
      tx_drop     <= 1'b0;
    end else begin
      if (rx_drop)      rx_overflow <= 1'b1;
      else if (clr_err) rx_overflow <= 1'b0;
      if (tx_drop_now)  tx_drop <= 1'b1;
      else if (clr_err) tx_drop <= 1'b0;
    end
  end

endmodule

// File: doc/buart_fifo.md
Name: buart_fifo

Overview:
- Buffering stage between the CPU IO port and the byte UART.
- Downstream of the UART receive path: a receive FIFO drains every received byte.
- Upstream of the UART transmit path: a transmit FIFO feeds queued bytes into the UART one at a time.
- Gives the CPU status bits and occupancy counts, so the CPU no longer has to poll per byte.

Parameters:
RX_AW, 4, log2 of receive FIFO depth (16 entries)
TX_AW, 4, log2 of transmit FIFO depth (16 entries)

Ports:
clk  input  1  system clock
resetq  input  1  reset, asynchronous, active-low
io_wr  input  1  CPU push of io_wdata into TX FIFO
io_wdata  input  8  byte to transmit
io_rd  input  1  CPU pop of RX FIFO head
io_rdata  output  8  RX FIFO head (first-word-fall-through)
rx_avail  output  1  RX FIFO non-empty
tx_full  output  1  TX FIFO full
rx_count  output  RX_AW+1  RX occupancy
tx_count  output  TX_AW+1  TX occupancy
rx_overflow  output  1  sticky: received byte dropped
tx_drop  output  1  sticky: CPU push dropped
clr_err  input  1  clears both sticky flags
uart_wr  output  1  one-cycle transmit strobe to UART
uart_tx_data  output  8  byte for UART
uart_busy  input  1  UART transmitter busy
uart_rd  output  1  acknowledge to UART receiver
uart_rx_data  input  8  received byte from UART
uart_valid  input  1  UART holds an unread byte

Behaviour:
- Reset: clk, resetq; resetq asynchronous, active-low. Asynchronous assert clears all pointers, counts, flags and the TX FSM.
- Output values during reset: rx_avail=0, tx_full=0, counts=0, flags=0, uart_wr=0, uart_tx_data=0, io_rdata=0.
- uart_rd is combinational, equal to uart_valid. It is held 0 while resetq is low.
- Reset mid-operation discards all FIFO contents. A byte already handed to the UART still completes on the line.
- RX path:
  - A byte is captured whenever uart_valid=1, in the same cycle uart_rd is asserted. The UART clears valid the following cycle, so no double capture occurs.
  - If the RX FIFO is full and io_rd=0 that cycle: the byte is dropped and rx_overflow is set. uart_rd is still asserted so the UART frees its buffer.
  - Full with io_rd=1 in the same cycle: pop and push both occur, the byte is accepted, and count is unchanged.
  - io_rd while empty: ignored; pointers and count unchanged.
  - io_rdata reflects the head entry combinationally from storage. It is valid only when rx_avail=1; otherwise the value is don't-care.
  - Pop takes effect at the clock edge; new head visible the next cycle.
- TX path:
  - io_wr when not full: push.
  - io_wr when full: the byte is dropped, tx_drop set.
  - io_wr when full while the FSM pops the same cycle: accepted.
  - Push to empty FIFO: the byte becomes eligible the next cycle (no bypass).
- TX FSM, states IDLE, HOLD:
  - IDLE: if TX non-empty and uart_busy=0, assert uart_wr for one cycle with uart_tx_data = head, pop, and go to HOLD.
  - HOLD: exactly one cycle, no strobe; return to IDLE. This covers the one-cycle lag before the UART raises busy.
  - Minimum spacing between uart_wr strobes is therefore 2 cycles. In practice spacing is the UART frame time.
  - uart_tx_data is registered and holds its value between strobes.
- Sticky flags: clr_err has priority below a same-cycle new error, i.e. the error sets the flag.
- Counts:
  - Pointers are RX_AW/TX_AW+1 bits wide with wrap bit; full when the MSBs differ and the low bits are equal.
  - count = wptr - rptr modulo 2^(AW+1); the range is 0..2^AW.

Decomposition:
- Shared package: FIFO pointer width helpers and TX FSM state encoding (IDLE=0, HOLD=1).
- One sub-module, byte_fifo (parameter AW): synchronous write, combinational head read, push, pop, full, empty, count.
  - Instantiated twice.
  - Same-cycle push-when-full-with-pop is resolved inside byte_fifo.

Test Plan:
- Reset with resetq=0 mid-transfer -> all outputs zero immediately (async); uart_rd=0 while in reset; counts 0 after release.
- UART delivers 0x41,0x42,0x43 -> uart_rd pulses once per byte; rx_count=3; io_rdata=0x41, then 0x42, then 0x43 on successive io_rd; rx_avail drops after the third pop.
- 17 bytes into RX (depth 16), no io_rd -> rx_count=16; rx_overflow=1; head 0x00 (first byte) intact. clr_err -> flag 0.
- RX full, uart_valid and io_rd in the same cycle -> rx_count stays 16, no overflow, new byte at tail.
- CPU pushes 0x55,0xAA with uart_busy model (rises 1 cycle after uart_wr, low after 20 cycles) -> exactly two uart_wr strobes ≥21 cycles apart, data 0x55 then 0xAA, tx_count 2→1→0.
- 17 io_wr with uart_busy held 1 -> tx_full=1 after 16; 17th sets tx_drop; releasing busy drains 16 bytes in order.
